// File: rtl/interp_row_sched.sv
// interp_row_sched: streams a block's reference rows into shift_reg and offers each
// completed 8-row window to the 8-tap filter under a valid/ready handshake.
module interp_row_sched #(
    parameter int ROW_W  = 120,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        frac_x,
    input  logic [1:0]        frac_y,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [ROW_W-1:0]  mem_rd_data,
    output logic              sr_load_L,
    output logic [ROW_W-1:0]  sr_in,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [2:0]        win_row,
    output logic [1:0]        win_frac_x,
    output logic [1:0]        win_frac_y
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WIN, DONE} state_t;
    state_t state, state_n;
    logic [3:0] row, row_n;
    logic [ADDR_W-1:0] base;
    logic [1:0] fx, fy;
    logic full, load;
    // A fractional vertical phase needs the full 15-row span; integer phase needs only rows 3..10.
    assign full = fy != 2'd0;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            row   <= 4'd0;
            base  <= '0;
            fx    <= 2'd0;
            fy    <= 2'd0;
        end else begin
            state <= state_n;
            row   <= row_n;
            if (state == IDLE && start) begin
                base <= base_addr;
                fx   <= frac_x;
                fy   <= frac_y;
            end
        end
    end
    always_comb begin
        state_n   = state;
        row_n     = row;
        mem_rd_en = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = FETCH;
                row_n   = frac_y != 2'd0 ? 4'd0 : 4'd3;
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                state_n   = LOAD;
            end
            LOAD: begin
                load = 1'b1;
                if (!full || row >= 4'd7) state_n = WIN;
                else begin
                    row_n     = row + 4'd1;
                    mem_rd_en = 1'b1;
                end
            end
            WIN: if (win_ready) begin
                if (row == (full ? 4'd14 : 4'd10)) state_n = DONE;
                else begin
                    row_n     = row + 4'd1;
                    mem_rd_en = 1'b1;
                    state_n   = LOAD;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // row_n is the row being requested whenever a read is issued (current row in FETCH, next row otherwise).
    assign mem_rd_addr = mem_rd_en ? base + ADDR_W'(row_n) : '0;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign sr_load_L   = !load;
    assign sr_in       = load ? mem_rd_data : '0;
    assign win_valid   = state == WIN;
    assign win_row     = win_valid ? 3'(row - (full ? 4'd7 : 4'd3)) : 3'd0;
    assign win_frac_x  = fx;
    assign win_frac_y  = fy;
endmodule

// File: tb/tb_interp_row_sched.sv
// tb_interp_row_sched: randomized scoreboard bench; a block-level model predicts reads,
// loaded rows, windows and done timing, and a negedge monitor checks them as they appear.
module tb_interp_row_sched;
    localparam int RW = 120;
    localparam int AW = 8;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0, win_ready = 1'b1;
    logic [1:0] frac_x = 2'd0, frac_y = 2'd0;
    logic [AW-1:0] base_addr = '0;
    logic busy, done, mem_rd_en, sr_load_L, win_valid;
    logic [AW-1:0] mem_rd_addr;
    logic [RW-1:0] mem_rd_data = '0, sr_in;
    logic [2:0] win_row;
    logic [1:0] win_frac_x, win_frac_y;
    logic [RW-1:0] mem [256];
    logic [AW-1:0] q_addr[$];
    logic [RW-1:0] q_data[$];
    logic [6:0] q_win[$];
    int cyc = 0, n_cmp = 0, n_err = 0;
    int acc_cyc = 0, exp_lat = 0, stalls = 0, ready_mode = 0, held = 0;
    bit pending = 0;

    interp_row_sched #(.ROW_W(RW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .frac_x(frac_x), .frac_y(frac_y),
        .base_addr(base_addr), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .sr_load_L(sr_load_L),
        .sr_in(sr_in), .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
        .win_frac_x(win_frac_x), .win_frac_y(win_frac_y)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failx(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    // Ready pattern: 0 always ready, 1 random, 2 hold off five cycles at window row 2.
    always @(posedge clock) begin
        #1;
        if (ready_mode == 0) win_ready = 1'b1;
        else if (ready_mode == 1) win_ready = $urandom_range(0, 3) != 0;
        else if (win_valid && win_row == 3'd2 && held < 5) begin
            win_ready = 1'b0;
            held++;
        end else win_ready = 1'b1;
    end

    always @(negedge clock) begin
        if (mem_rd_en) begin
            if (q_addr.size() == 0) failx("rd_extra");
            else chk("rd_addr", RW'(mem_rd_addr), RW'(q_addr.pop_front()));
            chk("rd_while_stalled", RW'(win_valid & !win_ready), RW'(0));
        end
        if (!sr_load_L) begin
            if (q_data.size() == 0) failx("load_extra");
            else chk("sr_in", sr_in, q_data.pop_front());
            chk("load_during_win", RW'(win_valid), RW'(0));
        end else chk("sr_in_idle", sr_in, '0);
        if (win_valid) begin
            if (q_win.size() == 0) failx("win_extra");
            else begin
                chk("win_row_frac", RW'({win_row, win_frac_x, win_frac_y}), RW'(q_win[0]));
                if (win_ready) void'(q_win.pop_front());
                else stalls++;
            end
        end
        if (done) begin
            if (!pending) failx("done_extra");
            else chk("done_cycle", RW'(cyc - acc_cyc), RW'(exp_lat + stalls));
            chk("busy_in_done", RW'(busy), RW'(1));
            pending = 0;
        end
        if (reset) begin
            q_addr.delete();
            q_data.delete();
            q_win.delete();
            pending = 0;
        end
    end

    task automatic issue(input logic [1:0] fx, input logic [1:0] fy, input logic [AW-1:0] b, input bit junk);
        int t = 0;
        @(negedge clock);
        while (busy && t < 300) begin
            if (junk) begin
                start     = 1'($urandom);
                frac_x    = 2'($urandom);
                frac_y    = 2'($urandom);
                base_addr = AW'($urandom);
            end
            t++;
            @(negedge clock);
        end
        if (busy) begin
            failx("idle_timeout");
            return;
        end
        start = 1'b1;
        frac_x = fx;
        frac_y = fy;
        base_addr = b;
        for (int r = (fy != 0 ? 0 : 3); r <= (fy != 0 ? 14 : 10); r++) begin
            q_addr.push_back(AW'(b + r));
            q_data.push_back(mem[AW'(b + r)]);
            if (fy == 0 || r >= 7) q_win.push_back({3'(r - (fy != 0 ? 7 : 3)), fx, fy});
        end
        acc_cyc = cyc;
        exp_lat = fy != 0 ? 25 : 18;
        stalls = 0;
        held = 0;
        pending = 1;
        @(posedge clock);
        #1;
        start = junk ? 1'($urandom) : 1'b0;
        if (junk) begin
            frac_x    = 2'($urandom);
            frac_y    = 2'($urandom);
            base_addr = AW'($urandom);
        end
    endtask

    task automatic finish_wait();
        int t = 0;
        @(negedge clock);
        start = 1'b0;
        while (busy && t < 300) begin
            t++;
            @(negedge clock);
        end
        if (busy) failx("finish_timeout");
        chk("done_seen", RW'(pending), RW'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", RW'(busy), RW'(0));
        chk("rst_done", RW'(done), RW'(0));
        chk("rst_rd_en", RW'(mem_rd_en), RW'(0));
        chk("rst_rd_addr", RW'(mem_rd_addr), RW'(0));
        chk("rst_load_L", RW'(sr_load_L), RW'(1));
        chk("rst_sr_in", sr_in, '0);
        chk("rst_win", RW'({win_valid, win_row, win_frac_x, win_frac_y}), RW'(0));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs();
        reset = 1'b0;
        issue(2'd1, 2'd2, 8'h10, 0);
        finish_wait();
        issue(2'd3, 2'd0, 8'h00, 0);
        finish_wait();
        ready_mode = 2;
        issue(2'd0, 2'd1, 8'h40, 0);
        finish_wait();
        chk("stall_count", RW'(stalls), RW'(5));
        ready_mode = 0;
        issue(2'd2, 2'd1, 8'd250, 0);
        finish_wait();
        issue(2'd1, 2'd3, 8'h80, 0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk_reset_outputs();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("busy_after_reset", RW'(busy), RW'(0));
        repeat (3) @(negedge clock);
        ready_mode = 1;
        repeat (30) issue(2'($urandom), 2'($urandom_range(0, 1) != 0 ? $urandom : 0), AW'($urandom), 1);
        finish_wait();
        chk("addr_queue_empty", RW'(q_addr.size()), RW'(0));
        chk("data_queue_empty", RW'(q_data.size()), RW'(0));
        chk("win_queue_empty", RW'(q_win.size()), RW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/interp_row_sched.md
# interp_row_sched

Sequences one prediction block's reference rows from the reference-window memory into the interpolation `shift_reg` (row width 15 pixels × 8 bits). It presents each completed 8-row filter window to the downstream 8-tap filter stage through a valid/ready handshake, with the block's fractional phase attached. It sits between the reference-window row memory and the `shift_reg`/filter datapath. It is the only driver of the shift register's load strobe.

## Interface
- `ROW_W`, 120, width of one reference row (15 pixels × 8 bits)
- `ADDR_W`, 8, reference-window memory row-address width
- `clock` in 1: the single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `start` in 1: request a block; accepted only while `busy`=0
- `frac_x` in 2: horizontal quarter-pel phase, latched at start
- `frac_y` in 2: vertical quarter-pel phase, latched at start
- `base_addr` in ADDR_W: memory row address of reference row 0, latched at start
- `busy` out 1: high from the accept cycle+1 through the DONE cycle
- `done` out 1: one-cycle pulse at end of block
- `mem_rd_en` out 1: memory read strobe; read data valid exactly one cycle later
- `mem_rd_addr` out ADDR_W: (latched `base_addr` + row) mod 2^ADDR_W
- `mem_rd_data` in ROW_W: read data
- `sr_load_L` out 1: active-low shift/load strobe to `shift_reg`
- `sr_in` out ROW_W: row to shift in; equals `mem_rd_data` combinationally while `sr_load_L`=0, else 0
- `win_valid` out 1: filter window ready in `shift_reg`
- `win_ready` in 1: filter stage accepts window
- `win_row` out 3: output row index 0..7 of current window
- `win_frac_x`, `win_frac_y` out 2 each: latched phases; valid whenever `win_valid`=1

## Operation
- Row range: `frac_y`≠0 gives rows 0..14 (15 loads, window after rows 7..14). `frac_y`=0 gives rows 3..10 (8 loads, window after every row). `frac_x` does not affect sequencing.
- `win_row` = row−7 (`frac_y`≠0) or row−3 (`frac_y`=0).
- States: IDLE, FETCH, LOAD, WIN, DONE.
- IDLE: `busy`=0. When `start`=1, latch inputs, set row=first row, go to FETCH.
- FETCH: `mem_rd_en`=1 for the current row. Go to LOAD.
- LOAD: `sr_load_L`=0 and `sr_in`=`mem_rd_data`.
  - If the row produces a window, go to WIN.
  - Otherwise increment row, assert `mem_rd_en` for the new row this same cycle, and stay in LOAD.
- WIN: `win_valid`=1. `win_row`/`win_frac_*` are stable and no load or read occurs until `win_ready`=1.
  - On accept with row=last, go to DONE.
  - On accept otherwise, increment row, assert `mem_rd_en` this cycle, and go to LOAD.
- DONE: `done`=1 and `busy`=1 for one cycle, then IDLE. `start` in DONE is ignored.
- `start` while `busy`=1 is ignored with no side effects.
- The controller never asserts `sr_load_L`=0 while `win_valid`=1.
- At most one read is in flight.

## Timing
- Reset (synchronous): next state IDLE, row=0, latched regs 0. Outputs: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `sr_load_L`=1, `sr_in`=0, `win_valid`=0, `win_row`=0, `win_frac_*`=0.
- Reset mid-block: the in-flight read is discarded, no load follows, and no `done` is issued.
- Reset has priority over `start` in the same cycle.
- Cycle numbering: c0 is the `start`-accept cycle. The timeline below assumes `win_ready`=1 throughout.
- `frac_y`≠0 timeline:
  - FETCH at c1.
  - LOAD rows 0..6 at c2..c8.
  - Row k≥7: LOAD at c(9+2(k−7)), WIN at c(10+2(k−7)).
  - DONE at c25, IDLE at c26.
- `frac_y`=0 timeline:
  - FETCH at c1.
  - Row k: LOAD at c(2+2(k−3)), WIN one cycle later.
  - DONE at c18.
- Each cycle `win_ready`=0 during WIN adds exactly one cycle.
- Address wrap: `base_addr`=250 with row 14 gives `mem_rd_addr`=8.

## Test plan
- Reset: hold `reset` 3 cycles mid-LOAD -> all outputs at reset values on the next cycle, no further `mem_rd_en`, `busy`=0.
- `frac_x`=1, `frac_y`=2, `base_addr`=0x10, `win_ready`=1 -> 15 reads at addresses 0x10..0x1E, 15 `sr_load_L` pulses, 8 windows with `win_row` 0..7 at c10,c12..c24, `done` at c25.
- `frac_y`=0, `frac_x`=3, `base_addr`=0 -> reads at rows 3..10 only, 8 windows at c3..c17, `win_frac_x`=3, `done` at c18.
- Backpressure: `win_ready`=0 for 5 cycles at `win_row`=2 -> `win_valid`, `win_row`=2 and `sr_load_L`=1 held for those 5 cycles, no `mem_rd_en`, and `done` is delayed by exactly 5 cycles.
- Back-to-back: `start` held high through a block -> second block accepted in the IDLE cycle after DONE; `start` during `busy` has no effect.
- Wrap: `base_addr`=250, `frac_y`=1 -> addresses 250..255 then 0..8; data passes to `sr_in` unchanged.
